// File: rtl/pipe_stage_reg.sv
// Valid/ready inter-stage register: 1-cycle latency, flush squashes held entries, saturating stall counter.
// Define PIPE_SKID_EN to add a skid entry so in_ready is registered; otherwise in_ready = ~out_valid | out_ready.
module pipe_stage_reg #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 160,
  parameter int RN_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RN_W-1:0]   in_rn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [RN_W-1:0]   out_rn,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [RN_W-1:0]   m_rn_q,   m_rn_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [RN_W-1:0]   s_rn_q,   s_rn_d;

  // Ready comes straight from the state flop, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != ST_SKID);
  assign out_valid = (state_q != ST_EMPTY);

  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    m_rn_d   = m_rn_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    s_rn_d   = s_rn_q;
    if (flush) begin
      state_d  = ST_EMPTY;
      m_ctrl_d = '0;
      m_rn_d   = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
            m_rn_d   = in_rn;
            state_d  = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
            m_rn_d   = in_rn;
          end else if (in_xfer) begin
            s_ctrl_d = in_ctrl;
            s_data_d = in_data;
            s_rn_d   = in_rn;
            state_d  = ST_SKID;
          end else if (out_xfer) begin
            m_ctrl_d = '0;
            m_rn_d   = '0;
            state_d  = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
            m_rn_d   = s_rn_q;
            state_d  = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_EMPTY;
      s_ctrl_q <= '0;
      s_data_q <= '0;
      s_rn_q   <= '0;
    end else begin
      state_q  <= state_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
      s_rn_q   <= s_rn_d;
    end
  end
`else
  logic m_valid_q, m_valid_d;

  assign in_ready  = ~m_valid_q | out_ready;
  assign out_valid = m_valid_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    m_rn_d    = m_rn_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
      m_rn_d    = '0;
    end else if (in_xfer) begin
      m_valid_d = 1'b1;
      m_ctrl_d  = in_ctrl;
      m_data_d  = in_data;
      m_rn_d    = in_rn;
    end else if (out_xfer) begin
      // Bubble: control and destination cleared, data left as-is.
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
      m_rn_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) m_valid_q <= 1'b0;
    else         m_valid_q <= m_valid_d;
  end
`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !flush && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      m_ctrl_q    <= '0;
      m_data_q    <= '0;
      m_rn_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      m_ctrl_q    <= m_ctrl_d;
      m_data_q    <= m_data_d;
      m_rn_q      <= m_rn_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_ctrl  = m_ctrl_q;
  assign out_data  = m_data_q;
  assign out_rn    = m_rn_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table, hand-written stall/saturation/reset sequences, random traffic vs a queue model.
module tb_pipe_stage_reg;
  localparam int CW   = 10;
  localparam int DW   = 160;
  localparam int RW   = 5;
  localparam int NW   = 4;
  localparam int NMAX = (1 << NW) - 1;
`ifdef PIPE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic          clock = 1'b0;
  logic          resetn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [RW-1:0] in_rn, out_rn;
  logic [NW-1:0] stall_cnt;

  always #5 clock = ~clock;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .RN_W(RW), .CNT_W(NW)) dut (
    .clock(clock), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_rn(in_rn),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_rn(out_rn),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [RW-1:0] r;
  } item_t;

  // Reference: an ordered queue of held instructions of capacity DEPTH.
  item_t         mq[$];
  logic [DW-1:0] m_last = '0;
  int            m_cnt = 0;
  bit            rdy_seen;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dpat(input logic [RW-1:0] r);
    return {32{r}};
  endfunction

  function automatic logic [CW-1:0] ctl(input logic [RW-1:0] r);
    return {r, ~r};
  endfunction

  function automatic bit model_ready(input bit ordy);
    if (DEPTH == 2) return mq.size() < 2;
    return (mq.size() == 0) || ordy;
  endfunction

  task automatic cycle(input bit rst_n, input bit fl, input bit iv, input logic [RW-1:0] r,
                       input bit ordy, input logic [CW-1:0] c, input logic [DW-1:0] d);
    bit    erdy;
    item_t it;
    resetn = rst_n; flush = fl; in_valid = iv; in_rn = r; in_ctrl = c; in_data = d;
    out_ready = ordy;
    erdy = model_ready(ordy);
    @(negedge clock);
    rdy_seen = in_ready;
    chk("in_ready", DW'(in_ready), DW'(erdy));
    if (!rst_n) begin
      mq.delete();
      m_last = '0;
      m_cnt  = 0;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && !ordy && m_cnt < NMAX) m_cnt++;
      if (mq.size() > 0 && ordy) void'(mq.pop_front());
      if (iv && erdy) begin
        it.c = c; it.d = d; it.r = r;
        mq.push_back(it);
      end
    end
    if (mq.size() > 0) m_last = mq[0].d;
    @(posedge clock);
    #1;
    chk("out_valid", DW'(out_valid), DW'(mq.size() > 0));
    chk("out_rn",    DW'(out_rn),    DW'(mq.size() > 0 ? mq[0].r : '0));
    chk("out_ctrl",  DW'(out_ctrl),  DW'(mq.size() > 0 ? mq[0].c : '0));
    chk("out_data",  out_data,       m_last);
    chk("stall_cnt", DW'(stall_cnt), DW'(m_cnt));
  endtask

  task automatic vcycle(input bit rst_n, input bit fl, input bit iv, input logic [RW-1:0] r, input bit ordy);
    cycle(rst_n, fl, iv, r, ordy, ctl(r), dpat(r));
  endtask

  typedef struct {
    bit            rst_n;
    bit            fl;
    bit            iv;
    logic [RW-1:0] rn;
    bit            e_vld;
    logic [RW-1:0] e_rn;
    logic [RW-1:0] e_drn;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [RW-1:0] rn;
    // resetn, flush, in_valid, in_rn -> out_valid, out_rn, rn whose data pattern is on out_data
    vt[0]  = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd1, 5'd1};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 5'd2, 5'd2};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 5'd3};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 5'd4, 5'd4};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 5'd4};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd4};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 5'd6, 5'd6};
    vt[10] = '{1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 5'd6};
    vt[11] = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd6};

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rn = '0; in_ctrl = '0; in_data = '0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 12; i++) begin
      vcycle(vt[i].rst_n, vt[i].fl, vt[i].iv, vt[i].rn, 1'b1);
      chk($sformatf("tbl%0d_ready", i), DW'(rdy_seen), DW'(1'b1));
      chk($sformatf("tbl%0d_valid", i), DW'(out_valid), DW'(vt[i].e_vld));
      chk($sformatf("tbl%0d_rn", i), DW'(out_rn), DW'(vt[i].e_rn));
      chk($sformatf("tbl%0d_ctrl", i), DW'(out_ctrl), DW'(vt[i].e_vld ? ctl(vt[i].e_rn) : '0));
      chk($sformatf("tbl%0d_data", i), out_data, dpat(vt[i].e_drn));
      chk($sformatf("tbl%0d_cnt", i), DW'(stall_cnt), '0);
    end

    // Stall with rn=7 held for five cycles, then release.
    vcycle(1'b1, 1'b0, 1'b1, 5'd7, 1'b1);
    for (int k = 0; k < 5; k++) begin
`ifdef PIPE_SKID_EN
      rn = (k == 0) ? 5'd8 : 5'd9;
      vcycle(1'b1, 1'b0, 1'b1, rn, 1'b0);
      chk($sformatf("stall%0d_ready", k), DW'(rdy_seen), DW'(k == 0));
`else
      vcycle(1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
      chk($sformatf("stall%0d_ready", k), DW'(rdy_seen), '0);
`endif
      chk($sformatf("stall%0d_rn", k), DW'(out_rn), DW'(5'd7));
    end
    chk("stall_cnt5", DW'(stall_cnt), DW'(5));
`ifdef PIPE_SKID_EN
    vcycle(1'b1, 1'b0, 1'b1, 5'd9, 1'b1);
    chk("release_ready", DW'(rdy_seen), '0);
`else
    vcycle(1'b1, 1'b0, 1'b1, 5'd8, 1'b1);
    chk("release_ready", DW'(rdy_seen), DW'(1'b1));
`endif
    chk("release_valid", DW'(out_valid), DW'(1'b1));
    chk("release_rn", DW'(out_rn), DW'(5'd8));

    // Saturation over 20 stalled cycles.
    vcycle(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    vcycle(1'b1, 1'b0, 1'b1, 5'd3, 1'b1);
    for (int k = 0; k < 20; k++) vcycle(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("sat_cnt", DW'(stall_cnt), DW'(NMAX));
    chk("sat_rn", DW'(out_rn), DW'(5'd3));
    vcycle(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("sat_hold", DW'(stall_cnt), DW'(NMAX));

    // Reset while stalled (and, with skid, while the skid entry is occupied).
    vcycle(1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
    vcycle(1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    chk("rst_valid", DW'(out_valid), '0);
    chk("rst_rn", DW'(out_rn), '0);
    chk("rst_ctrl", DW'(out_ctrl), '0);
    chk("rst_data", out_data, '0);
    chk("rst_cnt", DW'(stall_cnt), '0);
    chk("rst_ready", DW'(in_ready), DW'(1'b1));
    vcycle(1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    chk("rst_dropped", DW'(out_valid), '0);

    // Random traffic against the queue model.
    for (int k = 0; k < 1500; k++) begin
      cycle(($urandom % 50) != 0, ($urandom % 20) == 0, ($urandom % 10) < 7, RW'($urandom),
            ($urandom % 10) < 6, CW'($urandom),
            {$urandom, $urandom, $urandom, $urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the pipelined CPU, generalising the fixed decode/execute latch. It carries a control bundle, a data bundle and a destination register number between any two stages. It adds a valid/ready handshake, stall back-pressure, synchronous flush for bubble insertion and a saturating stall counter. An optional skid buffer breaks the combinational ready path between stages.

## Interface
- CTRL_W, 10: width of control bundle (wreg, m2reg, wmem, aluc, aluimm, shift, jal, ...); zeroed on bubble/flush
- DATA_W, 160: width of data bundle (a, b, imm, pc4, sa); held, not zeroed, on flush
- RN_W, 5: destination register number width
- CNT_W, 16: stall counter width
- clock  in  1  rising-edge clock
- resetn  in  1  reset, synchronous, active-low
- flush  in  1  kill all held entries this cycle (branch/jump squash)
- in_valid  in  1  upstream stage presents an instruction
- in_ready  out  1  this stage accepts on this edge
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- in_rn  in  RN_W  upstream destination register
- out_valid  out  1  downstream sees a valid instruction
- out_ready  in  1  downstream accepts on this edge
- out_ctrl  out  CTRL_W  registered control; all-zero whenever out_valid=0
- out_data  out  DATA_W  registered data
- out_rn  out  RN_W  registered destination; zero whenever out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Transfers: in-transfer = in_valid & in_ready; out-transfer = out_valid & out_ready.
- Main register (M): on an in-transfer with M empty or M draining (out-transfer), M loads in_*. out_valid is 1 on the next edge.
- M draining with no in-transfer: out_valid becomes 0 and out_ctrl/out_rn become 0 (bubble). out_data holds its last value.
- M full with no out-transfer: M holds and the stage is stalled.
- Flush: takes priority over everything. On the edge with flush=1, all valid bits clear, out_ctrl/out_rn clear and any in-transfer that cycle is discarded. in_ready is still reported per its normal equation; the discard is silent. stall_cnt is unaffected.
- stall_cnt: increments on each edge with out_valid & ~out_ready & ~flush. It saturates at 2^CNT_W-1 and never wraps. It clears only on reset.
- Reset (resetn=0 at edge): out_valid=0, out_ctrl=0, out_data=0, out_rn=0, stall_cnt=0, skid empty. Reset overrides flush and all transfers. Reset asserted mid-stall drops the held instruction.

## Timing
- Latency: 1 cycle from in-transfer to out_valid.
- Throughput: 1 instruction per cycle when out_ready=1 continuously.
- Without skid: in_ready = ~out_valid | out_ready, combinational from out_ready.
- With skid: in_ready = ~skid_valid, registered, with no combinational path from out_ready.
- Ready never depends on in_valid.
- Outputs change only on rising clock edges.

## Configuration
- PIPE_SKID_EN defined: adds a skid entry (S) and a 3-state FSM.
  - EMPTY: M and S invalid. An in-transfer goes to FULL.
  - FULL: M valid. An in-transfer without out-transfer loads S and goes to SKID. An out-transfer without in-transfer goes to EMPTY. Both together reload M and stay in FULL.
  - SKID: M and S valid and in_ready=0. An out-transfer moves S to M and goes to FULL.
  - Flush from any state goes to EMPTY.
- PIPE_SKID_EN undefined: single-entry register with no S. in_ready is combinational as above. Zero bubbles under continuous flow in both builds.

## Test plan
- Reset then stream: resetn=0 for 2 cycles, then in_valid=1, out_ready=1 with in_rn=1,2,3. Required: out_valid rises one cycle after the first transfer, out_rn=1,2,3 on consecutive cycles, and stall_cnt stays 0.
- Stall: M holds rn=7 and out_ready=0 for 5 cycles. Required: out_rn=7 stable and stall_cnt=5. Without skid, in_ready=0 throughout. With skid, in_ready=1 for one cycle, S captures the next input (rn=8), then in_ready=0. After release, order is 7 then 8.
- Flush with simultaneous input: out_valid=1, in_valid=1 and flush=1 on the same edge. Required: next cycle out_valid=0, out_ctrl=0, out_rn=0, and the input is never emitted.
- Bubble: an out-transfer with in_valid=0. Required: out_valid=0, out_ctrl=0 and out_data unchanged.
- Saturation: CNT_W=4 with out_ready=0 for 20 cycles. Required: stall_cnt=15 and held.
- Reset mid-skid (PIPE_SKID_EN): state SKID, then resetn=0. Required: next edge has all outputs 0 and in_ready=1.
